// File: rtl/turbo_ctrl_pkg.sv
// Shared definitions for the turbo decoder iteration controller and its datapath.
package turbo_ctrl_pkg;

  localparam int ADDR_W_DEF = 10;
  localparam int ITER_W_DEF = 4;
  localparam int DRAIN_DEF  = 6;

  // Controller state encoding, also decoded by the datapath top.
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_DEC1   = 3'd1,
    ST_DRAIN1 = 3'd2,
    ST_DEC2   = 3'd3,
    ST_DRAIN2 = 3'd4,
    ST_CHECK  = 3'd5,
    ST_OUT    = 3'd6,
    ST_DONE   = 3'd7
  } ctrl_state_t;

  // Bits needed to count 0..n-1 (at least one bit).
  function automatic int cnt_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/turbo_phase_cnt.sv
// Loadable up-counter with a terminal flag that is high while count equals limit.
module turbo_phase_cnt
  import turbo_ctrl_pkg::*;
#(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         en,
  input  logic [W-1:0] limit,
  output logic [W-1:0] count,
  output logic         term
);

  // Clear has priority over counting so a wrap on the terminal cycle lands on zero.
  always_ff @(posedge clk) begin
    if (!rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en) begin
      count <= count + 1'b1;
    end
  end

  assign term = (count == limit);

endmodule

// File: rtl/turbo_iter_ctrl.sv
// Iteration controller for a two-decoder turbo loop: sequences DEC1/DEC2
// half-iterations with pipeline drain gaps, checks for termination, then
// sweeps the output buffer.
module turbo_iter_ctrl
  import turbo_ctrl_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int ITER_W = ITER_W_DEF,
  parameter int DRAIN  = DRAIN_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] blk_words,
  input  logic [ITER_W-1:0] max_iter,
  input  logic              hd_match,
  output logic              ready,
  output logic              busy,
  output logic              dec1_en,
  output logic              dec2_en,
  output logic [ADDR_W-1:0] addr,
  output logic              zero_ext,
  output logic              out_valid,
  output logic [ITER_W-1:0] iter_cnt,
  output logic              done,
  output logic              early_stop
);

  localparam int DRN_W = cnt_w(DRAIN);
  localparam logic [DRN_W-1:0] DRN_LAST = DRN_W'(DRAIN - 1);

  ctrl_state_t state, nxt;

  logic [ADDR_W-1:0] blk_q;
  logic [ITER_W-1:0] max_q;

  logic              accept;
  logic              addr_en, addr_clr, addr_term;
  logic              drn_en, drn_clr, drn_term;
  logic [DRN_W-1:0]  drn_cnt;
  logic              iter_inc, es_set;

  // Word address shared by decoders, interleavers and the output buffer.
  turbo_phase_cnt #(.W(ADDR_W)) u_addr_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr   (addr_clr),
    .en    (addr_en),
    .limit (blk_q),
    .count (addr),
    .term  (addr_term)
  );

  // Flush gap after each half-iteration.
  turbo_phase_cnt #(.W(DRN_W)) u_drain_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr   (drn_clr),
    .en    (drn_en),
    .limit (DRN_LAST),
    .count (drn_cnt),
    .term  (drn_term)
  );

  assign drn_clr = accept | (drn_en & drn_term);

  // State register.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= ST_IDLE;
    end else begin
      state <= nxt;
    end
  end

  // Next-state and counter control decode.
  always_comb begin
    nxt      = state;
    accept   = 1'b0;
    addr_en  = 1'b0;
    addr_clr = 1'b0;
    drn_en   = 1'b0;
    iter_inc = 1'b0;
    es_set   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          accept   = 1'b1;
          addr_clr = 1'b1;
          nxt      = ST_DEC1;
        end
      end
      ST_DEC1: begin
        addr_en = 1'b1;
        if (addr_term) begin
          addr_clr = 1'b1;
          nxt      = ST_DRAIN1;
        end
      end
      ST_DRAIN1: begin
        drn_en = 1'b1;
        if (drn_term) nxt = ST_DEC2;
      end
      ST_DEC2: begin
        addr_en = 1'b1;
        if (addr_term) begin
          addr_clr = 1'b1;
          nxt      = ST_DRAIN2;
        end
      end
      ST_DRAIN2: begin
        drn_en = 1'b1;
        if (drn_term) begin
          iter_inc = 1'b1;
          nxt      = ST_CHECK;
        end
      end
      ST_CHECK: begin
        // A single completed iteration has nothing to compare against.
        if (iter_cnt == max_q) begin
          nxt = ST_OUT;
        end else if (hd_match && (iter_cnt >= ITER_W'(2))) begin
          es_set = 1'b1;
          nxt    = ST_OUT;
        end else begin
          nxt = ST_DEC1;
        end
      end
      ST_OUT: begin
        addr_en = 1'b1;
        if (addr_term) begin
          addr_clr = 1'b1;
          nxt      = ST_DONE;
        end
      end
      ST_DONE: begin
        nxt = ST_IDLE;
      end
      default: begin
        nxt = ST_IDLE;
      end
    endcase
  end

  // Frame parameters, iteration count and early-stop flag.
  always_ff @(posedge clk) begin
    if (!rst) begin
      blk_q      <= '0;
      max_q      <= '0;
      iter_cnt   <= '0;
      early_stop <= 1'b0;
    end else if (accept) begin
      blk_q      <= blk_words;
      max_q      <= (max_iter == '0) ? ITER_W'(1) : max_iter;
      iter_cnt   <= '0;
      early_stop <= 1'b0;
    end else begin
      if (iter_inc && (iter_cnt != max_q)) iter_cnt <= iter_cnt + 1'b1;
      if (es_set) early_stop <= 1'b1;
    end
  end

  assign ready     = (state == ST_IDLE);
  assign busy      = (state != ST_IDLE);
  assign dec1_en   = (state == ST_DEC1);
  assign dec2_en   = (state == ST_DEC2);
  assign zero_ext  = (state == ST_DEC1) && (iter_cnt == '0);
  assign out_valid = (state == ST_OUT);
  assign done      = (state == ST_DONE);

endmodule

// File: tb/tb_turbo_iter_ctrl.sv
// Self-checking bench for turbo_iter_ctrl: frame-level reference model,
// per-cycle output comparison, plus literal timing expectations.
module tb_turbo_iter_ctrl;

  localparam int AW = 6;
  localparam int IW = 4;
  localparam int D  = 2;

  localparam int M_IDLE = 0;
  localparam int M_ITER = 1;
  localparam int M_OUT  = 2;
  localparam int M_DONE = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic [AW-1:0] blk_words = '0;
  logic [IW-1:0] max_iter = '0;
  logic          hd_match = 1'b0;
  logic          ready, busy, dec1_en, dec2_en, zero_ext, out_valid, done, early_stop;
  logic [AW-1:0] addr;
  logic [IW-1:0] iter_cnt;

  int n_checks = 0;
  int n_pass   = 0;
  bit chk_en   = 1'b0;
  bit noise    = 1'b0;

  // reference model state
  int m_mode = M_IDLE;
  int m_r    = 0;
  int m_it   = 0;
  int m_es   = 0;
  int m_blk  = 0;
  int m_mx   = 0;
  int m_rel  = 0;

  bit [17:0] log_v [0:255];

  turbo_iter_ctrl #(.ADDR_W(AW), .ITER_W(IW), .DRAIN(D)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .blk_words  (blk_words),
    .max_iter   (max_iter),
    .hd_match   (hd_match),
    .ready      (ready),
    .busy       (busy),
    .dec1_en    (dec1_en),
    .dec2_en    (dec2_en),
    .addr       (addr),
    .zero_ext   (zero_ext),
    .out_valid  (out_valid),
    .iter_cnt   (iter_cnt),
    .done       (done),
    .early_stop (early_stop)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // Reference model: one iteration is DEC1 (L) + drain (D) + DEC2 (L) + drain (D) + CHECK.
  always @(posedge clk) begin
    int per;
    per = 2 * (m_blk + 1 + D) + 1;
    if (!rst) begin
      m_mode = M_IDLE; m_r = 0; m_it = 0; m_es = 0; m_blk = 0; m_mx = 0; m_rel = 0;
    end else begin
      case (m_mode)
        M_IDLE: begin
          if (start) begin
            m_blk  = int'(blk_words);
            m_mx   = (max_iter == 0) ? 1 : int'(max_iter);
            m_it   = 0; m_es = 0; m_r = 0;
            m_mode = M_ITER;
            m_rel  = 1;
          end
        end
        M_ITER: begin
          m_rel++;
          if (m_r == per - 1) begin
            m_r = 0;
            if (m_it == m_mx) m_mode = M_OUT;
            else if (hd_match && m_it >= 2) begin m_es = 1; m_mode = M_OUT; end
          end else begin
            m_r++;
            if (m_r == per - 1) m_it++;
          end
        end
        M_OUT: begin
          m_rel++;
          if (m_r == m_blk) begin m_r = 0; m_mode = M_DONE; end
          else m_r++;
        end
        default: begin
          m_mode = M_IDLE;
        end
      endcase
    end
  end

  // Compare DUT against the model on every falling edge.
  always @(negedge clk) begin
    bit [17:0] exp_v, act_v;
    int L;
    bit e_d1, e_d2, e_ov, e_dn;
    int e_addr;
    L = m_blk + 1;
    e_d1 = 0; e_d2 = 0; e_ov = 0; e_dn = 0; e_addr = 0;
    if (m_mode == M_ITER) begin
      if (m_r < L) begin e_d1 = 1; e_addr = m_r; end
      else if (m_r >= L + D && m_r < 2 * L + D) begin e_d2 = 1; e_addr = m_r - L - D; end
    end else if (m_mode == M_OUT) begin
      e_ov = 1; e_addr = m_r;
    end else if (m_mode == M_DONE) begin
      e_dn = 1;
    end
    exp_v = {m_mode == M_IDLE, m_mode != M_IDLE, e_d1, e_d2, e_d1 && (m_it == 0), e_ov, e_dn,
             m_es != 0, IW'(m_it), AW'(e_addr)};
    act_v = {ready, busy, dec1_en, dec2_en, zero_ext, out_valid, done, early_stop, iter_cnt, addr};
    if (chk_en) begin
      chk("cycle_outputs", int'(act_v), int'(exp_v));
      if (m_mode == M_DONE)
        chk("frame_latency", m_rel, 1 + m_it * (2 * (m_blk + 1 + D) + 1) + m_blk + 1);
      if (m_mode != M_IDLE && m_rel < 256) begin
        if (m_rel == 1) for (int k = 0; k < 256; k++) log_v[k] = '0;
        log_v[m_rel] = act_v;
      end
    end
  end

  task automatic apply_noise();
    if (noise) begin
      start     = ($urandom_range(0, 7) == 0);
      hd_match  = ($urandom_range(0, 2) == 0);
      blk_words = AW'($urandom_range(0, 12));
      max_iter  = IW'($urandom_range(0, 5));
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
    apply_noise();
  endtask

  task automatic run_until_done(input int bound);
    bit seen;
    seen = 0;
    for (int i = 0; i < bound && !seen; i++) begin
      @(negedge clk);
      if (done) seen = 1;
      #1;
      apply_noise();
    end
    n_checks++;
    if (seen) n_pass++;
    else $display("FAIL done_timeout: got no done within %0d cycles, required a done pulse", bound);
  endtask

  task automatic launch(input int b, input int mx, input bit hd);
    blk_words = AW'(b);
    max_iter  = IW'(mx);
    hd_match  = hd;
    start     = 1'b1;
    tick();
    start     = 1'b0;
  endtask

  initial begin
    int cnt1, cnt2, cnto, ndone;
    // reset
    rst = 1'b0;
    tick();
    chk_en = 1'b1;
    tick();
    chk("reset_state", int'({ready, busy, dec1_en, dec2_en, zero_ext, out_valid, done, early_stop, iter_cnt, addr}), 'h20000);
    rst = 1'b1;
    tick();

    // blk=3, max=2, no match: two full iterations
    launch(3, 2, 0);
    run_until_done(200);
    chk("a_dec1_c0",  log_v[0][15], 0);
    chk("a_dec1_c1",  log_v[1][15], 1);
    chk("a_dec1_c4",  log_v[4][15], 1);
    chk("a_dec1_c5",  log_v[5][15], 0);
    chk("a_dec2_c7",  log_v[7][14], 1);
    chk("a_dec2_c10", log_v[10][14], 1);
    chk("a_dec2_c11", log_v[11][14], 0);
    chk("a_ov_c27",   log_v[27][12], 1);
    chk("a_ov_c30",   log_v[30][12], 1);
    chk("a_done_c31", log_v[31][11], 1);
    chk("a_iter_c31", int'(log_v[31][9:6]), 2);
    chk("a_es_c31",   log_v[31][10], 0);
    tick();

    // max=8, hd_match held high: stops at second CHECK
    launch(3, 8, 1);
    run_until_done(400);
    chk("b_iter_c13", int'(log_v[13][9:6]), 1);
    chk("b_cont_c14", log_v[14][15], 1);
    chk("b_es_c26",   log_v[26][10], 0);
    chk("b_iter_c26", int'(log_v[26][9:6]), 2);
    chk("b_es_c27",   log_v[27][10], 1);
    chk("b_done_c31", log_v[31][11], 1);
    hd_match = 1'b0;
    tick();

    // max=0, blk=0: a single minimal iteration
    launch(0, 0, 0);
    run_until_done(100);
    cnt1 = 0; cnt2 = 0; cnto = 0;
    for (int k = 1; k < 20; k++) begin
      cnt1 += int'(log_v[k][15]);
      cnt2 += int'(log_v[k][14]);
      cnto += int'(log_v[k][12]);
    end
    chk("c_dec1_cycles", cnt1, 1);
    chk("c_dec2_cycles", cnt2, 1);
    chk("c_out_cycles",  cnto, 1);
    chk("c_zext_c1",  log_v[1][13], 1);
    chk("c_dec2_c4",  log_v[4][14], 1);
    chk("c_done_c9",  log_v[9][11], 1);
    tick();

    // reset during DEC2 of the first iteration aborts the frame
    launch(3, 2, 0);
    for (int i = 0; i < 50 && m_rel < 8; i++) tick();
    chk("d_in_dec2", int'(dec2_en), 1);
    rst = 1'b0;
    tick();
    rst = 1'b1;
    chk("d_after_rst", int'({ready, busy, dec1_en, dec2_en, zero_ext, out_valid, done, early_stop, iter_cnt, addr}), 'h20000);
    ndone = 0;
    for (int i = 0; i < 40; i++) begin tick(); ndone += int'(done); end
    chk("d_no_done", ndone, 0);
    launch(2, 1, 0);
    run_until_done(200);
    tick();

    // start held high: next frame accepted on the IDLE cycle after done
    blk_words = AW'(1);
    max_iter  = IW'(1);
    start     = 1'b1;
    run_until_done(200);
    tick();
    chk("e_idle_after_done", int'(ready), 1);
    tick();
    chk("e_rearm_dec1", int'(dec1_en), 1);
    run_until_done(200);
    start = 1'b0;
    tick();
    tick();

    // randomized frames, with start/hd/parameter noise and occasional aborts
    for (int f = 0; f < 30; f++) begin
      noise = 1'b0;
      start = 1'b0;
      for (int i = 0; i < 2000 && !ready; i++) tick();
      launch($urandom_range(0, 12), $urandom_range(0, 5), 0);
      noise = 1'b1;
      if (f % 6 == 5) begin
        for (int i = 0, n = $urandom_range(1, 60); i < n; i++) tick();
        rst = 1'b0;
        tick();
        rst = 1'b1;
      end else begin
        run_until_done(2000);
      end
    end
    noise = 1'b0;
    start = 1'b0;
    hd_match = 1'b0;
    for (int i = 0; i < 5; i++) tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
